// File: rtl/ysyx_22040365_mcore_pkg.sv
// Shared encodings for the ysyx_22040365 multi-cycle core: RV opcodes, FSM states, ALU ops.
package ysyx_22040365_mcore_pkg;

    localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
    localparam logic [6:0]  OPC_OP      = 7'b0110011;
    localparam logic [6:0]  OPC_LUI     = 7'b0110111;
    localparam logic [2:0]  F3_ADD      = 3'b000;
    localparam logic [6:0]  F7_ADD      = 7'b0000000;
    localparam logic [6:0]  F7_SUB      = 7'b0100000;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD      = 2'd0,
        ALU_SUB      = 2'd1,
        ALU_PASS_IMM = 2'd2
    } alu_op_e;

endpackage

// File: rtl/ysyx_22040365_rf2r.sv
// Register file: two combinational read ports, a debug read port, one synchronous write port.
module ysyx_22040365_rf2r #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(NREG)-1:0]  i_raddr1,
    input  logic [$clog2(NREG)-1:0]  i_raddr2,
    input  logic [$clog2(NREG)-1:0]  i_dbg_raddr,
    output logic [XLEN-1:0]          o_rdata1,
    output logic [XLEN-1:0]          o_rdata2,
    output logic [XLEN-1:0]          o_dbg_rdata,
    input  logic                     i_we,
    input  logic [$clog2(NREG)-1:0]  i_waddr,
    input  logic [XLEN-1:0]          i_wdata
);

    logic [XLEN-1:0] r_regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // x0 is forced to zero on every read port.
    assign o_rdata1    = (i_raddr1    == '0) ? '0 : r_regs[i_raddr1];
    assign o_rdata2    = (i_raddr2    == '0) ? '0 : r_regs[i_raddr2];
    assign o_dbg_rdata = (i_dbg_raddr == '0) ? '0 : r_regs[i_dbg_raddr];

endmodule

// File: rtl/ysyx_22040365_mcore.sv
// Multi-cycle addi/add/sub/lui/ebreak core: IDLE -> DECODE -> EXEC -> WB, HALT on ebreak/illegal.
module ysyx_22040365_mcore
    import ysyx_22040365_mcore_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NREG     = 32,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst,
    input  logic            inst_valid,
    output logic            inst_ready,
    output logic            commit_valid,
    output logic [4:0]      commit_rd,
    output logic [XLEN-1:0] commit_data,
    output logic [XLEN-1:0] pc,
    output logic            halted,
    output logic            illegal,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam int unsigned AW = $clog2(NREG);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    alu_op_e         r_alu_op;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_result;
    logic [XLEN-1:0] r_pc;
    logic            r_inst_ready;
    logic            r_commit_valid;
    logic [4:0]      r_commit_rd;
    logic [XLEN-1:0] r_commit_data;
    logic            r_halted;
    logic            r_illegal;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [AW-1:0]   w_rs1;
    logic [AW-1:0]   w_rs2;
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_rdata1;
    logic [XLEN-1:0] w_rdata2;
    logic            w_dec_valid;
    logic            w_is_ebreak;
    alu_op_e         w_dec_op;
    logic [XLEN-1:0] w_dec_op2;
    logic [XLEN-1:0] w_alu_res;

    assign w_opcode    = r_inst[6:0];
    assign w_f3        = r_inst[14:12];
    assign w_f7        = r_inst[31:25];
    assign w_rs1       = r_inst[15 +: AW];
    assign w_rs2       = r_inst[20 +: AW];
    assign w_rd        = r_inst[7 +: AW];
    assign w_imm_i     = XLEN'($signed(r_inst[31:20]));
    assign w_imm_u     = XLEN'($signed({r_inst[31:12], 12'b0}));
    assign w_is_ebreak = (r_inst == INST_EBREAK);

    ysyx_22040365_rf2r #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_rf (
        .clk         (clk),
        .rst         (rst),
        .i_raddr1    (w_rs1),
        .i_raddr2    (w_rs2),
        .i_dbg_raddr (dbg_raddr[AW-1:0]),
        .o_rdata1    (w_rdata1),
        .o_rdata2    (w_rdata2),
        .o_dbg_rdata (dbg_rdata),
        .i_we        (r_state == S_WB),
        .i_waddr     (r_rd),
        .i_wdata     (r_result)
    );

    // Classify the latched instruction and pick the second ALU operand.
    always_comb begin
        w_dec_valid = 1'b0;
        w_dec_op    = ALU_ADD;
        w_dec_op2   = w_rdata2;
        case (w_opcode)
            OPC_OP_IMM: begin
                if (w_f3 == F3_ADD) begin
                    w_dec_valid = 1'b1;
                    w_dec_op2   = w_imm_i;
                end
            end
            OPC_OP: begin
                if ((w_f3 == F3_ADD) && (w_f7 == F7_ADD)) begin
                    w_dec_valid = 1'b1;
                end else if ((w_f3 == F3_ADD) && (w_f7 == F7_SUB)) begin
                    w_dec_valid = 1'b1;
                    w_dec_op    = ALU_SUB;
                end
            end
            OPC_LUI: begin
                w_dec_valid = 1'b1;
                w_dec_op    = ALU_PASS_IMM;
                w_dec_op2   = w_imm_u;
            end
            default: w_dec_valid = 1'b0;
        endcase
    end

    always_comb begin
        case (r_alu_op)
            ALU_ADD:      w_alu_res = r_op1 + r_op2;
            ALU_SUB:      w_alu_res = r_op1 - r_op2;
            ALU_PASS_IMM: w_alu_res = r_op2;
            default:      w_alu_res = r_op2;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (inst_valid) w_state_nxt = S_DECODE;
            S_DECODE: w_state_nxt = w_dec_valid ? S_EXEC : S_HALT;
            S_EXEC:   w_state_nxt = S_WB;
            S_WB:     w_state_nxt = S_IDLE;
            S_HALT:   w_state_nxt = S_HALT;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; every output flop is timed off the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inst         <= '0;
            r_op1          <= '0;
            r_op2          <= '0;
            r_alu_op       <= ALU_ADD;
            r_rd           <= '0;
            r_result       <= '0;
            r_pc           <= RESET_PC[XLEN-1:0];
            r_inst_ready   <= 1'b1;
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
            r_halted       <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_inst_ready   <= (w_state_nxt == S_IDLE);
            r_commit_valid <= (r_state == S_EXEC);
            case (r_state)
                S_IDLE: begin
                    if (inst_valid) r_inst <= inst;
                end
                S_DECODE: begin
                    r_op1    <= w_rdata1;
                    r_op2    <= w_dec_op2;
                    r_alu_op <= w_dec_op;
                    r_rd     <= w_rd;
                    if (!w_dec_valid) begin
                        r_halted  <= 1'b1;
                        r_illegal <= !w_is_ebreak;
                    end
                end
                S_EXEC: begin
                    r_result      <= w_alu_res;
                    r_commit_rd   <= (r_rd == '0) ? 5'd0 : 5'(r_rd);
                    r_commit_data <= (r_rd == '0) ? '0 : w_alu_res;
                end
                S_WB: begin
                    r_pc <= r_pc + XLEN'(4);
                end
                default: ;
            endcase
        end
    end

    assign inst_ready   = r_inst_ready;
    assign commit_valid = r_commit_valid;
    assign commit_rd    = r_commit_rd;
    assign commit_data  = r_commit_data;
    assign pc           = r_pc;
    assign halted       = r_halted;
    assign illegal      = r_illegal;

endmodule
